// File: rtl/cpu_types_pkg.sv
// rtl/cpu_types_pkg.sv - shared bus types and scheduler constants
package cpu_types_pkg;

    typedef logic [31:0] word_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        IACC = 2'd1,
        DACC = 2'd2,
        DONE = 2'd3
    } sched_state_t;

    // Returned on the port whose RAM access timed out
    localparam word_t SCHED_BAD_DATA = 32'hBAD1BAD1;

endpackage

// File: rtl/sat_counter.sv
// rtl/sat_counter.sv - saturating up-counter with synchronous clear
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         clr,
    input  logic         en,
    output logic [W-1:0] q
);

    // Count enabled events, holding at all-ones instead of wrapping
    always_ff @(posedge clk) begin
        if (clr) begin
            q <= '0;
        end else if (en && (q != '1)) begin
            q <= q + 1'b1;
        end
    end

endmodule

// File: rtl/mem_request_sched.sv
// rtl/mem_request_sched.sv - single-port RAM arbiter between fetch and data ports
module mem_request_sched
    import cpu_types_pkg::*;
#(
    parameter int WAIT_MAX = 16,
    parameter int CNT_W    = 16
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             iREN,
    input  word_t            iaddr,
    output logic             ihit,
    output word_t            iload,
    input  logic             dREN,
    input  logic             dWEN,
    input  word_t            daddr,
    input  word_t            dstore,
    output logic             dhit,
    output word_t            dload,
    input  logic             halt,
    output logic             ramREN,
    output logic             ramWEN,
    output word_t            ramaddr,
    output word_t            ramstore,
    input  word_t            ramload,
    input  logic             ramready,
    output logic             halted,
    output logic             err,
    output logic [CNT_W-1:0] icnt,
    output logic [CNT_W-1:0] dcnt
);

    localparam int WAIT_W = (WAIT_MAX > 1) ? $clog2(WAIT_MAX) : 1;
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(WAIT_MAX - 1);

    sched_state_t      state, nextState;
    logic [WAIT_W-1:0] waitCnt;
    word_t             capAddr, capStore;
    logic              capWr, servedData;
    logic              haltL, errReg;
    word_t             iloadReg, dloadReg;

    logic dReq, iGrant, inAcc, lastWait;

    assign dReq     = dREN | dWEN;
    assign iGrant   = iREN & ~haltL;
    assign inAcc    = (state == IACC) || (state == DACC);
    assign lastWait = (waitCnt == WAIT_LAST);

    // Next state: data wins in IDLE, accesses end on ready or timeout, DONE lasts one cycle
    always_comb begin
        nextState = state;
        case (state)
            IDLE: begin
                if (dReq) begin
                    nextState = DACC;
                end else if (iGrant) begin
                    nextState = IACC;
                end
            end
            IACC, DACC: begin
                if (ramready || lastWait) begin
                    nextState = DONE;
                end
            end
            default: nextState = IDLE;
        endcase
    end

    // State, request capture, wait counter, load registers and sticky flags
    always_ff @(posedge CLK) begin
        if (RST) begin
            state      <= IDLE;
            waitCnt    <= '0;
            capAddr    <= '0;
            capStore   <= '0;
            capWr      <= 1'b0;
            servedData <= 1'b0;
            haltL      <= 1'b0;
            errReg     <= 1'b0;
            iloadReg   <= '0;
            dloadReg   <= '0;
        end else begin
            state <= nextState;
            if (halt) begin
                haltL <= 1'b1;
            end
            case (state)
                IDLE: begin
                    waitCnt <= '0;
                    if (dReq) begin
                        capAddr    <= daddr;
                        capStore   <= dstore;
                        capWr      <= dWEN;
                        servedData <= 1'b1;
                    end else if (iGrant) begin
                        capAddr    <= iaddr;
                        capStore   <= '0;
                        capWr      <= 1'b0;
                        servedData <= 1'b0;
                    end
                end
                IACC, DACC: begin
                    waitCnt <= waitCnt + 1'b1;
                    if (ramready) begin
                        if (!capWr) begin
                            if (state == IACC) begin
                                iloadReg <= ramload;
                            end else begin
                                dloadReg <= ramload;
                            end
                        end
                    end else if (lastWait) begin
                        errReg <= 1'b1;
                        if (state == IACC) begin
                            iloadReg <= SCHED_BAD_DATA;
                        end else begin
                            dloadReg <= SCHED_BAD_DATA;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign ramREN   = (state == IACC) || ((state == DACC) && !capWr);
    assign ramWEN   = (state == DACC) && capWr;
    assign ramaddr  = inAcc ? capAddr : '0;
    assign ramstore = inAcc ? capStore : '0;
    assign ihit     = (state == DONE) && !servedData;
    assign dhit     = (state == DONE) && servedData;
    assign iload    = iloadReg;
    assign dload    = dloadReg;
    assign halted   = haltL && (state == IDLE) && !dReq;
    assign err      = errReg;

    sat_counter #(.W(CNT_W)) u_icnt (
        .clk (CLK),
        .clr (RST),
        .en  (ihit),
        .q   (icnt)
    );

    sat_counter #(.W(CNT_W)) u_dcnt (
        .clk (CLK),
        .clr (RST),
        .en  (dhit),
        .q   (dcnt)
    );

endmodule

// File: tb/tb_mem_request_sched.sv
// tb/tb_mem_request_sched.sv - self-checking bench for mem_request_sched
module tb_mem_request_sched;

    localparam int WAIT_MAX = 16;
    localparam int CNT_W    = 4;
    localparam int CNT_MAX  = (1 << CNT_W) - 1;

    logic              CLK = 1'b0;
    logic              RST;
    logic              iREN, dREN, dWEN, halt, ramready;
    logic [31:0]       iaddr, daddr, dstore, ramload;
    logic              ihit, dhit, ramREN, ramWEN, halted, err;
    logic [31:0]       iload, dload, ramaddr, ramstore;
    logic [CNT_W-1:0]  icnt, dcnt;

    int total = 0;
    int bad   = 0;
    bit checkOn = 1'b0;

    mem_request_sched #(.WAIT_MAX(WAIT_MAX), .CNT_W(CNT_W)) dut (
        .CLK(CLK), .RST(RST),
        .iREN(iREN), .iaddr(iaddr), .ihit(ihit), .iload(iload),
        .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
        .dhit(dhit), .dload(dload), .halt(halt),
        .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
        .ramload(ramload), .ramready(ramready),
        .halted(halted), .err(err), .icnt(icnt), .dcnt(dcnt)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
        end
    endtask

    // Reference model: which port is being served, for how many cycles, and who is owed a hit
    int          busyPort;   // -1 none, 0 instruction, 1 data
    int          hitPort;    // -1 none, else port whose hit is shown this cycle
    int          accCycles;
    bit          capWrM;
    logic [31:0] capAddrM, capStoreM;
    bit          haltSeen, errM;
    logic [31:0] loadM [2];
    int          cntM [2];
    bit          doneEdge [2];

    always @(posedge CLK) begin
        doneEdge[0] = 1'b0;
        doneEdge[1] = 1'b0;
        if (RST) begin
            busyPort = -1; hitPort = -1; accCycles = 0;
            capWrM = 1'b0; capAddrM = '0; capStoreM = '0;
            haltSeen = 1'b0; errM = 1'b0;
            loadM[0] = '0; loadM[1] = '0; cntM[0] = 0; cntM[1] = 0;
        end else begin
            if (hitPort >= 0) begin
                if (cntM[hitPort] < CNT_MAX) cntM[hitPort]++;
                doneEdge[hitPort] = 1'b1;
                hitPort = -1;
            end else if (busyPort >= 0) begin
                if (ramready) begin
                    if (!capWrM) loadM[busyPort] = ramload;
                    hitPort = busyPort;
                    busyPort = -1;
                end else if (accCycles == WAIT_MAX - 1) begin
                    errM = 1'b1;
                    loadM[busyPort] = 32'hBAD1BAD1;
                    hitPort = busyPort;
                    busyPort = -1;
                end else begin
                    accCycles++;
                end
            end else if (dREN || dWEN) begin
                busyPort = 1; accCycles = 0;
                capWrM = dWEN; capAddrM = daddr; capStoreM = dstore;
            end else if (iREN && !haltSeen) begin
                busyPort = 0; accCycles = 0;
                capWrM = 1'b0; capAddrM = iaddr; capStoreM = '0;
            end
            if (halt) haltSeen = 1'b1;
        end
    end

    // Every-cycle comparison of all outputs against the model, away from the clock edge
    always @(negedge CLK) begin
        if (checkOn) begin
            chk("cyc_ramREN", 32'(ramREN), 32'(busyPort >= 0 && !capWrM));
            chk("cyc_ramWEN", 32'(ramWEN), 32'(busyPort == 1 && capWrM));
            chk("cyc_ramaddr", ramaddr, (busyPort >= 0) ? capAddrM : 32'h0);
            if (busyPort != 0)
                chk("cyc_ramstore", ramstore, (busyPort == 1) ? capStoreM : 32'h0);
            chk("cyc_ihit", 32'(ihit), 32'(hitPort == 0));
            chk("cyc_dhit", 32'(dhit), 32'(hitPort == 1));
            chk("cyc_iload", iload, loadM[0]);
            chk("cyc_dload", dload, loadM[1]);
            chk("cyc_halted", 32'(halted),
                32'(haltSeen && busyPort < 0 && hitPort < 0 && !(dREN || dWEN)));
            chk("cyc_err", 32'(err), 32'(errM));
            chk("cyc_icnt", 32'(icnt), 32'(cntM[0]));
            chk("cyc_dcnt", 32'(dcnt), 32'(cntM[1]));
        end
    end

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    int stallLeft = 0;

    initial begin
        RST = 1'b1; iREN = 0; dREN = 0; dWEN = 0; halt = 0; ramready = 0;
        iaddr = 0; daddr = 0; dstore = 0; ramload = 0;
        step();
        checkOn = 1'b1;
        step();
        chk("rst_ramREN", 32'(ramREN), 32'h0);
        chk("rst_ihit", 32'(ihit), 32'h0);
        chk("rst_icnt", 32'(icnt), 32'h0);
        chk("rst_err", 32'(err), 32'h0);
        chk("rst_halted", 32'(halted), 32'h0);
        RST = 1'b0;

        // 1: single fetch, ready in first access cycle
        iREN = 1; iaddr = 32'h40;
        step();
        chk("t1_ramREN", 32'(ramREN), 32'h1);
        chk("t1_ramaddr", ramaddr, 32'h40);
        ramready = 1; ramload = 32'h8C010004;
        step();
        chk("t1_ihit", 32'(ihit), 32'h1);
        chk("t1_iload", iload, 32'h8C010004);
        iREN = 0; ramready = 0;
        step();
        chk("t1_icnt", 32'(icnt), 32'h1);

        // 2: simultaneous requests, data first
        iREN = 1; iaddr = 32'h44; dREN = 1; daddr = 32'h100;
        step();
        chk("t2_daddr", ramaddr, 32'h100);
        ramready = 1; ramload = 32'h11112222;
        step();
        chk("t2_dhit", 32'(dhit), 32'h1);
        dREN = 0; ramready = 0;
        step();
        step();
        chk("t2_iaddr", ramaddr, 32'h44);
        ramready = 1; ramload = 32'h33334444;
        step();
        chk("t2_ihit", 32'(ihit), 32'h1);
        iREN = 0; ramready = 0;
        step();

        // 3: write with three wait cycles, inputs wiggled mid-access
        dWEN = 1; daddr = 32'h200; dstore = 32'hDEADBEEF;
        step();
        for (int k = 0; k < 4; k++) begin
            chk("t3_ramWEN", 32'(ramWEN), 32'h1);
            chk("t3_addr", ramaddr, 32'h200);
            chk("t3_store", ramstore, 32'hDEADBEEF);
            daddr = 32'h999; dstore = 32'h5555AAAA;
            if (k == 3) ramready = 1;
            step();
        end
        chk("t3_dhit", 32'(dhit), 32'h1);
        chk("t3_dload_kept", dload, 32'h11112222);
        dWEN = 0; ramready = 0;
        step();
        chk("t3_dcnt", 32'(dcnt), 32'h2);

        // 4: timeout after WAIT_MAX access cycles
        iREN = 1; iaddr = 32'h80;
        step();
        for (int k = 0; k < WAIT_MAX; k++) begin
            chk("t4_waiting", 32'(ramREN), 32'h1);
            step();
        end
        chk("t4_ihit", 32'(ihit), 32'h1);
        chk("t4_err", 32'(err), 32'h1);
        chk("t4_iload", iload, 32'hBAD1BAD1);
        iREN = 0;
        step();
        step();
        chk("t4_err_sticky", 32'(err), 32'h1);

        // 5: halt during a fetch
        iREN = 1; iaddr = 32'h90;
        step();
        halt = 1; ramready = 1; ramload = 32'h12345678;
        step();
        chk("t5_ihit", 32'(ihit), 32'h1);
        halt = 0; ramready = 0;
        step();
        chk("t5_halted", 32'(halted), 32'h1);
        step();
        chk("t5_no_fetch", 32'(ramREN), 32'h0);
        dREN = 1; daddr = 32'h300;
        #1;
        chk("t5_halted_dreq", 32'(halted), 32'h0);
        step();
        chk("t5_daddr", ramaddr, 32'h300);
        ramready = 1; ramload = 32'hCAFEF00D;
        step();
        chk("t5_dload", dload, 32'hCAFEF00D);
        dREN = 0; ramready = 0; iREN = 0;
        step();

        // 6: reset in the second data access cycle
        dREN = 1; daddr = 32'h400;
        step();
        step();
        RST = 1;
        step();
        chk("t6_ramREN", 32'(ramREN), 32'h0);
        chk("t6_ramWEN", 32'(ramWEN), 32'h0);
        chk("t6_dhit", 32'(dhit), 32'h0);
        chk("t6_err", 32'(err), 32'h0);
        chk("t6_icnt", 32'(icnt), 32'h0);
        chk("t6_dcnt", 32'(dcnt), 32'h0);
        RST = 0; dREN = 0;
        step();

        // Random traffic; the every-cycle compare does the checking
        for (int c = 0; c < 6000; c++) begin
            RST  = ($urandom_range(0, 399) == 0);
            halt = ($urandom_range(0, 299) == 0);
            if (iREN) begin
                if (doneEdge[0] && $urandom_range(0, 1) == 0) iREN = 0;
            end else if ($urandom_range(0, 2) == 0) begin
                iREN = 1;
            end
            if ((dREN || dWEN) && doneEdge[1]) begin
                dREN = 1'($urandom_range(0, 1));
                dWEN = 1'($urandom_range(0, 1));
            end else if (!(dREN || dWEN) && $urandom_range(0, 3) == 0) begin
                case ($urandom_range(0, 2))
                    0: begin dREN = 1; dWEN = 0; end
                    1: begin dREN = 0; dWEN = 1; end
                    default: begin dREN = 1; dWEN = 1; end
                endcase
            end
            if ($urandom_range(0, 1) == 0) iaddr = $urandom;
            if ($urandom_range(0, 1) == 0) daddr = $urandom;
            if ($urandom_range(0, 1) == 0) dstore = $urandom;
            ramload = $urandom;
            if (stallLeft > 0) begin
                ramready = 0;
                stallLeft--;
            end else begin
                if ($urandom_range(0, 79) == 0) stallLeft = 20;
                ramready = ($urandom_range(0, 2) == 0);
            end
            step();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
